// File: rtl/matrix_transpose_stream.sv
// Streaming N x N transpose of packed complex elements, with optional Hermitian
// conjugation; rows are buffered in full, then drained column by column.

module mts_conj_lane #(
    parameter int W = 16
) (
    input  logic         i_conj,
    input  logic [W-1:0] i_elem,
    output logic [W-1:0] o_elem
);
    localparam int H = W / 2;

    logic [H-1:0] w_im;
    logic [H-1:0] w_im_neg;

    assign w_im = i_elem[H-1:0];

    // The most negative imaginary value has no positive twin; clamp it to max.
    always_comb begin
        if (w_im == {1'b1, {(H-1){1'b0}}}) w_im_neg = {1'b0, {(H-1){1'b1}}};
        else                               w_im_neg = -w_im;
    end

    assign o_elem = i_conj ? {i_elem[W-1:H], w_im_neg} : i_elem;
endmodule

module matrix_transpose_stream #(
    parameter int N = 4,
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           herm,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W-1:0] in_row,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*W-1:0] out_row,
    output logic           out_last,
    output logic           done
);
    localparam int            CW   = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;
    typedef logic [N-1:0][W-1:0] row_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_herm_q;
    logic          r_done, w_done_nxt;
    row_t          r_buf [N];
    row_t          w_out;
    logic          w_in_acc, w_out_acc;
    logic [CW-1:0] w_wr_idx, w_col;

    assign in_ready  = (r_state != DRAIN);
    assign out_valid = (r_state == DRAIN);
    assign w_in_acc  = in_valid && in_ready;
    assign w_out_acc = out_valid && out_ready;
    assign out_last  = out_valid && (r_cnt == LAST);
    assign done      = r_done;
    assign out_row   = w_out;
    assign w_wr_idx  = (r_state == IDLE) ? '0 : r_cnt;
    // Column c sits at packed index N-1-c inside a stored row.
    assign w_col     = LAST - r_cnt;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: if (w_in_acc) begin
                w_state_nxt = FILL;
                w_cnt_nxt   = CW'(1);
            end
            FILL: if (w_in_acc) begin
                if (r_cnt == LAST) begin
                    w_state_nxt = DRAIN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            DRAIN: if (w_out_acc) begin
                if (r_cnt == LAST) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_herm_q <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
            if (r_state == IDLE && w_in_acc) r_herm_q <= herm;
        end
    end

    // Buffer is datapath only; stale contents are never visible while out_valid=0.
    always_ff @(posedge clk) begin
        if (w_in_acc) r_buf[w_wr_idx] <= in_row;
    end

    for (genvar j = 0; j < N; j++) begin : g_lane
        mts_conj_lane #(.W(W)) u_lane (
            .i_conj (r_herm_q),
            .i_elem (r_buf[j][w_col]),
            .o_elem (w_out[N-1-j])
        );
    end
endmodule

// File: tb/tb_matrix_transpose_stream.sv
// Directed bench for matrix_transpose_stream at N=4/W=16, N=2/W=8 and N=8/W=32.

module tb_matrix_transpose_stream;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic        herm = 0, in_valid = 0, out_ready = 1;
    logic [63:0] in_row = '0;
    logic        in_ready, out_valid, out_last, done;
    logic [63:0] out_row;

    logic        a_herm = 0, a_in_valid = 0, a_out_ready = 1;
    logic [15:0] a_in_row = '0;
    logic        a_in_ready, a_out_valid, a_out_last, a_done;
    logic [15:0] a_out_row;

    logic         b_herm = 0, b_in_valid = 0, b_out_ready = 1;
    logic [255:0] b_in_row = '0;
    logic         b_in_ready, b_out_valid, b_out_last, b_done;
    logic [255:0] b_out_row;

    matrix_transpose_stream #(.N(4), .W(16)) u_dut (
        .clk(clk), .reset_n(reset_n), .herm(herm), .in_valid(in_valid),
        .in_ready(in_ready), .in_row(in_row), .out_valid(out_valid),
        .out_ready(out_ready), .out_row(out_row), .out_last(out_last), .done(done));

    matrix_transpose_stream #(.N(2), .W(8)) u_dut_n2 (
        .clk(clk), .reset_n(reset_n), .herm(a_herm), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .in_row(a_in_row), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_row(a_out_row), .out_last(a_out_last), .done(a_done));

    matrix_transpose_stream #(.N(8), .W(32)) u_dut_n8 (
        .clk(clk), .reset_n(reset_n), .herm(b_herm), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .in_row(b_in_row), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_row(b_out_row), .out_last(b_out_last), .done(b_done));

    typedef struct packed {
        logic             herm;
        logic [3:0][63:0] rows;
        logic [3:0][63:0] exp;
    } vec_t;

    vec_t tbl [3];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic set_vec(input int k, input logic h,
                           input logic [63:0] r0, r1, r2, r3, e0, e1, e2, e3);
        tbl[k].herm    = h;
        tbl[k].rows[0] = r0; tbl[k].rows[1] = r1; tbl[k].rows[2] = r2; tbl[k].rows[3] = r3;
        tbl[k].exp[0]  = e0; tbl[k].exp[1]  = e1; tbl[k].exp[2]  = e2; tbl[k].exp[3]  = e3;
    endtask

    // Feed one matrix then drain it; all actions happen on the falling edge.
    task automatic run_matrix(input int k, input bit gap, input bit tog, input int bp,
                              input bit junk, input bit b2b);
        vec_t v;
        v = tbl[k];
        for (int i = 0; i < 4; i++) begin
            if (gap && i > 0) begin
                in_valid = 0;
                in_row   = 64'hDEAD_BEEF_DEAD_BEEF;
                herm     = ~v.herm;
                repeat (2) @(negedge clk);
            end
            chk($sformatf("m%0d_in_ready_r%0d", k, i), in_ready, 1);
            in_valid = 1;
            in_row   = v.rows[i];
            herm     = (i == 0) ? v.herm : (tog ? ~v.herm : v.herm);
            @(negedge clk);
        end
        in_valid = junk;
        in_row   = 64'hBAD0_BAD0_BAD0_BAD0;
        herm     = ~v.herm;
        chk($sformatf("m%0d_latency_valid", k), out_valid, 1);
        chk($sformatf("m%0d_drain_in_ready", k), in_ready, 0);
        for (int r = 0; r < 4; r++) begin
            if (r == bp) begin
                out_ready = 0;
                repeat (3) begin
                    chk($sformatf("m%0d_bp_row%0d", k, r), out_row, v.exp[r]);
                    chk($sformatf("m%0d_bp_valid", k), out_valid, 1);
                    chk($sformatf("m%0d_bp_last", k), out_last, (r == 3));
                    @(negedge clk);
                end
            end
            out_ready = 1;
            chk($sformatf("m%0d_valid%0d", k, r), out_valid, 1);
            chk($sformatf("m%0d_row%0d", k, r), out_row, v.exp[r]);
            chk($sformatf("m%0d_last%0d", k, r), out_last, (r == 3));
            @(negedge clk);
        end
        in_valid = 0;
        chk($sformatf("m%0d_done", k), done, 1);
        chk($sformatf("m%0d_valid_after", k), out_valid, 0);
        if (!b2b) begin
            @(negedge clk);
            chk($sformatf("m%0d_done_pulse", k), done, 0);
        end
    endtask

    initial begin
        logic [15:0]  a_rows [2][2];
        logic [15:0]  a_exp  [2][2];
        logic [255:0] b_exp;

        set_vec(0, 1'b0,
                64'h0000_0001_0002_0003, 64'h0004_0005_0006_0007,
                64'h0008_0009_000A_000B, 64'h000C_000D_000E_000F,
                64'h0000_0004_0008_000C, 64'h0001_0005_0009_000D,
                64'h0002_0006_000A_000E, 64'h0003_0007_000B_000F);
        set_vec(1, 1'b1,
                64'h0000_0305_0780_0900, 64'h0101_0102_0103_0104,
                64'h0201_0202_0203_0204, 64'h0301_0302_0303_0304,
                64'h0000_01FF_02FF_03FF, 64'h03FB_01FE_02FE_03FE,
                64'h077F_01FD_02FD_03FD, 64'h0900_01FC_02FC_03FC);
        set_vec(2, 1'b0,
                64'h0000_0305_0780_0900, 64'h0101_0102_0103_0104,
                64'h0201_0202_0203_0204, 64'h0301_0302_0303_0304,
                64'h0000_0101_0201_0301, 64'h0305_0102_0202_0302,
                64'h0780_0103_0203_0303, 64'h0900_0104_0204_0304);

        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_done", done, 0);
        chk("rst_in_ready", in_ready, 1);
        reset_n = 1;
        @(negedge clk);

        for (int k = 0; k < 3; k++) run_matrix(k, 0, 0, -1, 0, 0);

        run_matrix(0, 0, 0, 2, 1, 0);
        run_matrix(1, 1, 1, -1, 0, 0);
        run_matrix(2, 1, 1, -1, 0, 0);

        // Partial matrix, then an asynchronous reset in the middle of a cycle.
        for (int i = 0; i < 2; i++) begin
            in_valid = 1; in_row = tbl[1].rows[i]; herm = 1;
            @(negedge clk);
        end
        in_valid = 0;
        #2 reset_n = 0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_done", done, 0);
        @(negedge clk);
        reset_n = 1;
        chk("rel_out_valid", out_valid, 0);
        chk("rel_in_ready", in_ready, 1);
        run_matrix(0, 0, 0, -1, 0, 0);

        run_matrix(0, 0, 0, -1, 0, 1);
        run_matrix(1, 0, 0, -1, 0, 1);
        run_matrix(2, 0, 0, -1, 0, 0);

        // N=2, W=8: plain transpose, then conjugate with an imaginary -8 clamping to 7.
        a_rows[0][0] = 16'h0001; a_rows[0][1] = 16'h0203;
        a_exp[0][0]  = 16'h0002; a_exp[0][1]  = 16'h0103;
        a_rows[1][0] = 16'h1827; a_rows[1][1] = 16'h3F41;
        a_exp[1][0]  = 16'h1731; a_exp[1][1]  = 16'h294F;
        for (int v = 0; v < 2; v++) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("n2_in_ready%0d", i), a_in_ready, 1);
                a_in_valid = 1; a_in_row = a_rows[v][i]; a_herm = (v == 1);
                @(negedge clk);
            end
            a_in_valid = 0;
            for (int r = 0; r < 2; r++) begin
                chk($sformatf("n2_v%0d_valid%0d", v, r), a_out_valid, 1);
                chk($sformatf("n2_v%0d_row%0d", v, r), a_out_row, a_exp[v][r]);
                chk($sformatf("n2_v%0d_last%0d", v, r), a_out_last, (r == 1));
                @(negedge clk);
            end
            chk($sformatf("n2_v%0d_done", v), a_done, 1);
            @(negedge clk);
        end

        // N=8, W=32: element (i,j) = 8*i+j, so output row r element j = 8*j+r.
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("n8_in_ready%0d", i), b_in_ready, 1);
            b_in_valid = 1;
            for (int j = 0; j < 8; j++) b_in_row[32*(8-j)-1 -: 32] = 32'(i*8 + j);
            @(negedge clk);
        end
        b_in_valid = 0;
        for (int r = 0; r < 8; r++) begin
            for (int j = 0; j < 8; j++) b_exp[32*(8-j)-1 -: 32] = 32'(j*8 + r);
            chk($sformatf("n8_valid%0d", r), b_out_valid, 1);
            chk($sformatf("n8_row%0d", r), b_out_row, b_exp);
            chk($sformatf("n8_last%0d", r), b_out_last, (r == 7));
            @(negedge clk);
        end
        chk("n8_done", b_done, 1);
        chk("n8_valid_after", b_out_valid, 0);
        @(negedge clk);
        chk("n8_done_pulse", b_done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/matrix_transpose_stream.md
MATRIX_TRANSPOSE_STREAM -- requirements
Module: matrix_transpose_stream

Interface
REQ-001 SHALL have parameter N, default 4: matrix dimension (N x N), legal range 2..8.
REQ-002 SHALL have parameter W, default 16: element width in bits, even, legal range 4..32; upper W/2 bits are the real part, lower W/2 bits the imaginary part, both two's complement.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port herm, input, 1: 1 = Hermitian transpose (conjugate), 0 = plain transpose; sampled with the first row of each matrix.
REQ-006 SHALL have port in_valid, input, 1: in_row carries a valid input row.
REQ-007 SHALL have port in_ready, output, 1: the block accepts a row this cycle.
REQ-008 SHALL have port in_row, input, N*W: one input row; element column j occupies bits [W*(N-j)-1 : W*(N-j-1)], so column 0 is at the MSBs.
REQ-009 SHALL have port out_valid, output, 1: out_row carries a valid output row.
REQ-010 SHALL have port out_ready, input, 1: the downstream block accepts out_row this cycle.
REQ-011 SHALL have port out_row, output, N*W: one output row, using the same element packing as in_row.
REQ-012 SHALL have port out_last, output, 1: high together with out_valid on output row N-1.
REQ-013 SHALL have port done, output, 1: one-cycle pulse after the complete matrix has drained.

Function
REQ-014 SHALL implement states IDLE, FILL and DRAIN, with a row counter of width $clog2(N).
REQ-015 SHALL treat a row as accepted when in_valid && in_ready at a rising edge, and an output as accepted when out_valid && out_ready at a rising edge.
REQ-016 SHALL drive in_ready=1 in IDLE and FILL, and in_ready=0 in DRAIN.
REQ-017 SHALL, in IDLE, on acceptance: store the row as buffer row 0, latch herm into herm_q, move to FILL, and set the counter to 1.
REQ-018 SHALL, in FILL, store each accepted row at buffer row = counter and increment the counter; on acceptance of row N-1, move to DRAIN with the counter cleared to 0.
REQ-019 SHALL ignore herm changes after the first row of a matrix until the next IDLE acceptance.
REQ-020 SHALL drive out_valid=1 exactly when in DRAIN.
REQ-021 SHALL drive out_row element j = buffer[j][counter], i.e. column counter of the input becomes output row counter.
REQ-022 SHALL, when herm_q=1, replace the imaginary part of each output element with its negation, saturating -2^(W/2-1) to 2^(W/2-1)-1; the real part passes unchanged.
REQ-023 SHALL hold out_row, out_valid and out_last stable while out_valid && !out_ready.
REQ-024 SHALL, on each output acceptance, increment the counter; on acceptance with counter = N-1, return to IDLE and assert done, a registered output, for exactly the next cycle.
REQ-025 SHALL produce the first out_valid in the cycle immediately after the edge that accepts input row N-1, giving a latency of 1 cycle and a minimum of 2N cycles per matrix.
REQ-026 SHALL NOT overlap fill and drain; a new matrix may be accepted in the cycle done is high, since the block is in IDLE.
REQ-027 SHALL hold state and counter unchanged when in_valid=0 during FILL (input gaps permitted) and when out_ready=0 during DRAIN.
REQ-028 SHALL NOT reset the buffer contents; out_row is don't-care whenever out_valid=0.

Reset
REQ-029 SHALL, while reset_n=0, immediately force: state=IDLE, counter=0, herm_q=0, out_valid=0, out_last=0, done=0, in_ready=1 (after reset release).
REQ-030 SHALL, when reset is asserted mid-FILL or mid-DRAIN, discard the partial matrix; the first row accepted after release is row 0 of a new matrix.

Verification
REQ-031 SHALL cover plain transpose: N=4, W=16, herm=0, rows 0x0000_0001_0002_0003, 0x0004_0005_0006_0007, 0x0008_0009_000A_000B, 0x000C_000D_000E_000F -> outputs 0x0000_0004_0008_000C, 0x0001_0005_0009_000D, 0x0002_0006_000A_000E, 0x0003_0007_000B_000F; out_last on the 4th output; done one cycle later.
REQ-032 SHALL cover Hermitian mode: herm=1 on row 0, element (0,1)=0x0305 -> output element (1,0)=0x03FB; element 0x0780 -> 0x077F (saturation); element 0x0900 -> 0x0900.
REQ-033 SHALL cover backpressure: out_ready=0 for 3 cycles on output row 2 -> out_row constant and no counter advance; then out_ready=1 -> remaining rows in order.
REQ-034 SHALL cover input gaps and herm toggling: in_valid deasserted between rows and herm toggled after row 0 -> result identical to the gap-free run using the row-0 herm value.
REQ-035 SHALL cover reset mid-operation: reset_n pulsed low after 2 rows accepted -> out_valid=0 and in_ready=1 after release; a fresh 4-row matrix transposes correctly.
REQ-036 SHALL cover back-to-back matrices and parameters: a new row 0 presented while done=1 is accepted; repeat REQ-031 with N=2, W=8 and with N=8, W=32.
